// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - reads back a multiplexed active-low seven-segment bus into a hex word
module seven_seg_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   word,
    output logic                  word_valid,
    output logic [DIGITS-1:0]     digit_err
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [7:0]            cnt, cnt_next;
    logic [6:0]            s_seg, p_seg;
    logic [DIGITS-1:0]     s_an, p_an;
    logic                  load_p, capture;
    logic                  an_ok;
    logic [4:0]            dec;
    logic [DIGITS-1:0]     seen, seen_eff, seen_with, cap_mask;
    logic                  frame_done, pending;
    logic [4*DIGITS-1:0]   frame_buf;
    logic [DIGITS-1:0]     err_buf;

    // Returns {illegal, nibble}; illegal glyphs decode to nibble 0
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        case (g)
            7'b0000001: return 5'h00;
            7'b1001111: return 5'h01;
            7'b0010010: return 5'h02;
            7'b0000110: return 5'h03;
            7'b1001100: return 5'h04;
            7'b0100100: return 5'h05;
            7'b0100000: return 5'h06;
            7'b0001111: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0000100: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b1100000: return 5'h0B;
            7'b0110001: return 5'h0C;
            7'b1000010: return 5'h0D;
            7'b0110000: return 5'h0E;
            7'b0111000: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    always_comb begin
        logic [DIGITS-1:0] lit;
        lit   = ~s_an;
        an_ok = (lit != '0) && ((lit & (lit - 1'b1)) == '0);
    end

    assign dec = decode_glyph(s_seg);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_p     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (an_ok) begin
                    load_p   = 1'b1;
                    cnt_next = 8'd1;
                    if (STABLE == 8'd1) begin
                        capture    = 1'b1;
                        state_next = HELD;
                    end else begin
                        state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!an_ok) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (s_seg == p_seg && s_an == p_an) begin
                    cnt_next = cnt + 8'd1;
                    if (cnt + 8'd1 >= STABLE) begin
                        capture    = 1'b1;
                        state_next = HELD;
                    end
                end else begin
                    load_p   = 1'b1;
                    cnt_next = 8'd1;
                    if (STABLE == 8'd1) begin
                        capture    = 1'b1;
                        state_next = HELD;
                    end
                end
            end
            HELD: begin
                // Segment changes on the same anode are ignored until the anode moves
                if (!an_ok) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (s_an != p_an) begin
                    load_p   = 1'b1;
                    cnt_next = 8'd1;
                    if (STABLE == 8'd1) begin
                        capture = 1'b1;
                    end else begin
                        state_next = SETTLE;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // seen is treated as already cleared while a completion is being published
    assign cap_mask   = capture ? ~s_an : '0;
    assign seen_eff   = pending ? '0 : seen;
    assign seen_with  = seen_eff | cap_mask;
    assign frame_done = capture && (&seen_with);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg      <= 7'b1111111;
            s_an       <= '1;
            p_seg      <= 7'b1111111;
            p_an       <= '1;
            state      <= IDLE;
            cnt        <= '0;
            seen       <= '0;
            pending    <= 1'b0;
            frame_buf  <= '0;
            err_buf    <= '0;
            word       <= '0;
            digit_err  <= '0;
            word_valid <= 1'b0;
        end else begin
            s_seg   <= seg;
            s_an    <= an;
            state   <= state_next;
            cnt     <= cnt_next;
            if (load_p) begin
                p_seg <= s_seg;
                p_an  <= s_an;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_mask[i]) begin
                    frame_buf[4*i +: 4] <= dec[3:0];
                    err_buf[i]          <= dec[4];
                end
            end
            seen       <= seen_with;
            pending    <= frame_done;
            word_valid <= pending;
            if (pending) begin
                word      <= frame_buf;
                digit_err <= err_buf;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] word;
    logic        word_valid;
    logic [3:0]  digit_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcount = 0;
    int vcyc = 0;
    int drive_cyc = 0;
    int base;

    localparam logic [6:0] BLANK = 7'b1111111;

    seven_seg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .word       (word),
        .word_valid (word_valid),
        .digit_err  (digit_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (word_valid) begin
            vcount = vcount + 1;
            vcyc   = cyc;
        end
    end

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            default: return BLANK;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; leaves time just after a rising edge
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an        = a;
        seg       = s;
        drive_cyc = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        logic [3:0] a;
        a = 4'b1111;
        a[d] = 1'b0;
        drive(a, s, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an  = 4'b1111;
        seg = BLANK;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'b1111;
        seg = BLANK;
        @(posedge clk);
        #1;
        do_reset();
        check("reset_word", 32'(word), 32'h0);
        check("reset_err", 32'(digit_err), 32'h0);
        check("reset_valid", 32'(word_valid), 32'h0);

        // Basic scan 1,2,3,4
        base = vcount;
        show(0, glyph(1), 8);
        show(1, glyph(2), 8);
        show(2, glyph(3), 8);
        show(3, glyph(4), 8);
        check("t1_latency", 32'(vcyc - drive_cyc), 32'd6);
        drive(4'b1111, BLANK, 4);
        check("t1_count", 32'(vcount - base), 32'd1);
        check("t1_word", 32'(word), 32'h4321);
        check("t1_err", 32'(digit_err), 32'h0);

        // Digit 2 too short to qualify, then a full rescan
        do_reset();
        base = vcount;
        show(0, glyph(1), 8);
        show(1, glyph(2), 8);
        show(2, glyph(3), 3);
        show(3, glyph(4), 8);
        drive(4'b1111, BLANK, 4);
        check("t2_no_valid", 32'(vcount - base), 32'd0);
        show(0, glyph(1), 8);
        show(1, glyph(2), 8);
        show(2, glyph(3), 8);
        show(3, glyph(4), 8);
        drive(4'b1111, BLANK, 4);
        check("t2_count", 32'(vcount - base), 32'd1);
        check("t2_word", 32'(word), 32'h4321);

        // Blank glyph on digit 1
        do_reset();
        base = vcount;
        show(0, glyph(15), 8);
        show(1, BLANK, 8);
        show(2, glyph(15), 8);
        show(3, glyph(15), 8);
        drive(4'b1111, BLANK, 4);
        check("t3_count", 32'(vcount - base), 32'd1);
        check("t3_word", 32'(word), 32'hFF0F);
        check("t3_err", 32'(digit_err), 32'h2);

        // Two anodes low between captures
        do_reset();
        base = vcount;
        show(0, glyph(5), 8);
        show(1, glyph(6), 8);
        drive(4'b1100, glyph(8), 10);
        check("t4_no_valid", 32'(vcount - base), 32'd0);
        show(2, glyph(7), 8);
        show(3, glyph(8), 8);
        drive(4'b1111, BLANK, 4);
        check("t4_count", 32'(vcount - base), 32'd1);
        check("t4_word", 32'(word), 32'h8765);

        // Digit 0 overwritten before frame completes
        do_reset();
        base = vcount;
        show(0, glyph(10), 8);
        drive(4'b1111, BLANK, 3);
        show(0, glyph(5), 8);
        show(1, glyph(1), 8);
        show(2, glyph(2), 8);
        show(3, glyph(3), 8);
        drive(4'b1111, BLANK, 4);
        check("t5_count", 32'(vcount - base), 32'd1);
        check("t5_word", 32'(word), 32'h3215);
        check("t5_err", 32'(digit_err), 32'h0);

        // Reset during digit 3 settle
        do_reset();
        show(0, glyph(1), 8);
        show(1, glyph(2), 8);
        show(2, glyph(3), 8);
        base = vcount;
        show(3, glyph(4), 3);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        an  = 4'b1111;
        seg = BLANK;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'b1111, BLANK, 6);
        check("t6_no_valid", 32'(vcount - base), 32'd0);
        check("t6_word_rst", 32'(word), 32'h0);
        check("t6_err_rst", 32'(digit_err), 32'h0);
        show(0, glyph(8), 8);
        show(1, glyph(9), 8);
        show(2, glyph(10), 8);
        show(3, glyph(11), 8);
        drive(4'b1111, BLANK, 4);
        check("t6_count", 32'(vcount - base), 32'd1);
        check("t6_word", 32'(word), 32'hBA98);
        check("t6_err", 32'(digit_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
